// File: rtl/mips_controller.sv
// Multi-cycle MIPS-style control unit: Moore FSM driving datapath strobes and mux selects.
// Optional ILLEGAL_OP_HALT_EN: illegal decodes park in HALT (halted=1) until reset instead of acting as NOP.
module mips_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_bus,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        mem_write,
  output logic        mem_read,
  output logic        IR_write,
  output logic        reg_write_en,
  output logic        mem_adr_sel,
  output logic        reg_write_adr_sel,
  output logic        ALU_src_A_sel,
  output logic [2:0]  reg_write_sel,
  output logic [1:0]  ALU_src_B_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  ALU_op_code,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LD_MEM, S_LD_WB, S_ST_MEM, S_JMP, S_BRZ,
    S_EX_R, S_EX_I, S_WB, S_MOVETO, S_MOVEFROM, S_NOT, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_write_en;
    logic       mem_adr_sel;
    logic       reg_write_adr_sel;
    logic       alu_src_a_sel;
    logic [2:0] reg_write_sel;
    logic [1:0] alu_src_b_sel;
    logic [1:0] pc_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_out;
  logic [1:0] dec_op;
  logic       illegal;
  logic       unused_ri;

  // Ri is consumed by the datapath, not by the controller.
  assign unused_ri = ^inst_bus[11:9];

  function automatic ctrl_t ctrl_for(input state_t s, input logic [1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read      = 1'b1;
        c.mem_adr_sel   = 1'b1;
        c.ir_write      = 1'b1;
        c.alu_src_a_sel = 1'b1;
        c.alu_src_b_sel = 2'd1;
        c.alu_op        = ALU_ADD;
        c.pc_sel        = 2'd3;
        c.pc_write      = 1'b1;
      end
      S_LD_MEM: c.mem_read = 1'b1;
      S_LD_WB: begin
        c.reg_write_en      = 1'b1;
        c.reg_write_adr_sel = 1'b1;
        c.reg_write_sel     = 3'd4;
      end
      S_ST_MEM: c.mem_write = 1'b1;
      S_JMP: begin
        c.pc_sel   = 2'd2;
        c.pc_write = 1'b1;
      end
      S_BRZ: begin
        c.alu_src_b_sel = 2'd2;
        c.alu_op        = ALU_SUB;
        c.pc_sel        = 2'd1;
        c.pc_write_cond = 1'b1;
      end
      S_EX_R: begin
        c.alu_src_b_sel = 2'd2;
        c.alu_op        = op;
      end
      S_EX_I: c.alu_op = op;
      S_WB: begin
        c.reg_write_en      = 1'b1;
        c.reg_write_adr_sel = 1'b1;
        c.reg_write_sel     = 3'd1;
      end
      S_MOVETO: begin
        c.reg_write_en  = 1'b1;
        c.reg_write_sel = 3'd3;
      end
      S_MOVEFROM: begin
        c.reg_write_en      = 1'b1;
        c.reg_write_adr_sel = 1'b1;
        c.reg_write_sel     = 3'd2;
      end
      S_NOT: begin
        c.reg_write_en      = 1'b1;
        c.reg_write_adr_sel = 1'b1;
        c.reg_write_sel     = 3'd0;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    dec_op  = ALU_ADD;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        casez (inst_bus[15:12])
          4'b0000: state_d = S_LD_MEM;
          4'b0001: state_d = S_ST_MEM;
          4'b0010: state_d = S_JMP;
          4'b0100: state_d = S_BRZ;
          4'b1000: begin
            case (inst_bus[8:0])
              9'h001:  state_d = S_MOVETO;
              9'h002:  state_d = S_MOVEFROM;
              9'h004:  begin state_d = S_EX_R; dec_op = ALU_ADD; end
              9'h008:  begin state_d = S_EX_R; dec_op = ALU_SUB; end
              9'h010:  begin state_d = S_EX_R; dec_op = ALU_AND; end
              9'h020:  begin state_d = S_EX_R; dec_op = ALU_OR;  end
              9'h040:  state_d = S_NOT;
              9'h080:  state_d = S_FETCH;
              default: illegal = 1'b1;
            endcase
          end
          // Immediate opcodes carry the ALU op in their low two bits.
          4'b11??: begin
            state_d = S_EX_I;
            dec_op  = inst_bus[13:12];
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef ILLEGAL_OP_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_LD_MEM: state_d = S_LD_WB;
      S_EX_R:   state_d = S_WB;
      S_EX_I:   state_d = S_WB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, dec_op);
  end

`ifdef ILLEGAL_OP_HALT_EN
  logic halted_q, halted_d;
  assign halted_d = (state_d == S_HALT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ctrl_q   <= ctrl_for(S_FETCH, ALU_ADD);
`ifdef ILLEGAL_OP_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
`ifdef ILLEGAL_OP_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Reset masks every output immediately, even mid-instruction.
  assign ctrl_out = rst ? '0 : ctrl_q;

  assign pc_write          = ctrl_out.pc_write;
  assign pc_write_cond     = ctrl_out.pc_write_cond;
  assign mem_write         = ctrl_out.mem_write;
  assign mem_read          = ctrl_out.mem_read;
  assign IR_write          = ctrl_out.ir_write;
  assign reg_write_en      = ctrl_out.reg_write_en;
  assign mem_adr_sel       = ctrl_out.mem_adr_sel;
  assign reg_write_adr_sel = ctrl_out.reg_write_adr_sel;
  assign ALU_src_A_sel     = ctrl_out.alu_src_a_sel;
  assign reg_write_sel     = ctrl_out.reg_write_sel;
  assign ALU_src_B_sel     = ctrl_out.alu_src_b_sel;
  assign pc_sel            = ctrl_out.pc_sel;
  assign ALU_op_code       = ctrl_out.alu_op;

`ifdef ILLEGAL_OP_HALT_EN
  assign halted = ~rst & halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller: per-instruction cycle model feeding an expected queue,
// checked every cycle, plus hand-computed literal vectors for key cycles.
module tb_mips_controller;

  logic        clk;
  logic        rst;
  logic [15:0] inst_bus;
  logic        pc_write, pc_write_cond, mem_write, mem_read, IR_write, reg_write_en;
  logic        mem_adr_sel, reg_write_adr_sel, ALU_src_A_sel;
  logic [2:0]  reg_write_sel;
  logic [1:0]  ALU_src_B_sel, pc_sel, ALU_op_code;
  logic        halted;

  int tests;
  int failures;
  logic [18:0] exp_q[$];
  logic [18:0] dut_vec;

  mips_controller dut (
    .clk(clk), .rst(rst), .inst_bus(inst_bus),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .mem_write(mem_write),
    .mem_read(mem_read), .IR_write(IR_write), .reg_write_en(reg_write_en),
    .mem_adr_sel(mem_adr_sel), .reg_write_adr_sel(reg_write_adr_sel),
    .ALU_src_A_sel(ALU_src_A_sel), .reg_write_sel(reg_write_sel),
    .ALU_src_B_sel(ALU_src_B_sel), .pc_sel(pc_sel), .ALU_op_code(ALU_op_code),
    .halted(halted)
  );

  assign dut_vec = {pc_write, pc_write_cond, mem_write, mem_read, IR_write, reg_write_en,
                    mem_adr_sel, reg_write_adr_sel, ALU_src_A_sel, reg_write_sel,
                    ALU_src_B_sel, pc_sel, ALU_op_code, halted};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output vector builder
  function automatic logic [18:0] mk(input logic pcw, input logic pcwc, input logic mw,
                                     input logic mr, input logic irw, input logic rwe,
                                     input logic mas, input logic rwas, input logic asa,
                                     input int rws, input int bsel, input int psel,
                                     input int op, input logic h);
    logic [2:0] r;
    logic [1:0] b, p, o;
    r = rws[2:0]; b = bsel[1:0]; p = psel[1:0]; o = op[1:0];
    return {pcw, pcwc, mw, mr, irw, rwe, mas, rwas, asa, r, b, p, o, h};
  endfunction

  function automatic logic [18:0] fetch_v();
    return mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 3, 0, 0);
  endfunction

  // Model: instruction -> the list of output vectors it produces, one per cycle.
  task automatic model_push(input logic [15:0] inst, output bit halts);
    int opc, ones, idx;
    halts = 0;
    opc = int'(inst[15:12]);
    exp_q.push_back(fetch_v());
    exp_q.push_back('0);
    if (opc == 0) begin
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 0, 0));
    end else if (opc == 1) begin
      exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end else if (opc == 2) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    end else if (opc == 4) begin
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    end else if (opc >= 12) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, opc - 12, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    end else begin
      ones = 0;
      idx  = 0;
      for (int k = 0; k < 9; k++) if (inst[k]) begin ones++; idx = k; end
      if (opc == 8 && ones == 1 && idx <= 7) begin
        if (idx == 0) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
        else if (idx == 1) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0));
        else if (idx == 6) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        else if (idx >= 2 && idx <= 5) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, idx - 2, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        end
      end else begin
`ifdef ILLEGAL_OP_HALT_EN
        halts = 1;
        repeat (4) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
      end
    end
  endtask

  // scoreboard: one compare per cycle with an expectation
  always @(negedge clk) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL cycle_check t=%0t inst=%h got=%h exp=%h", $time, inst_bus, dut_vec, e);
      end
    end
  end

  task automatic lit_check(input string name, input logic [18:0] want);
    tests++;
    if (dut_vec !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, dut_vec, want);
    end
  endtask

  // driver: runs one instruction; optional literal check at cycle lit_idx
  task automatic run_inst(input logic [15:0] inst, input int lit_idx, input logic [18:0] lit_val,
                          input string name);
    bit halts;
    int len;
    inst_bus = inst;
    model_push(inst, halts);
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == lit_idx) lit_check(name, lit_val);
      @(posedge clk);
      #1;
      if (i == 1) inst_bus = 16'($urandom_range(0, 65535));
    end
    if (halts) begin
      rst = 1'b1;
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    rst = 1'b1;
    inst_bus = 16'h0000;
    @(posedge clk);
    #1;
    repeat (2) begin
      exp_q.push_back('0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    run_inst(16'h0005, 0, 19'h4D438, "load_fetch");
    run_inst(16'h0005, 2, 19'h08000, "load_ld_mem");
    run_inst(16'h0005, 3, 19'h02A00, "load_ld_wb");
    run_inst(16'h1003, -1, '0, "store");
    run_inst(16'h2010, -1, '0, "jump");
    run_inst(16'h4012, 2, 19'h2004A, "brz_cycle");
    run_inst(16'h8604, 2, 19'h00040, "add_ex_r");
    run_inst(16'h8608, -1, '0, "sub");
    run_inst(16'h8610, -1, '0, "and");
    run_inst(16'h8620, -1, '0, "or");
    run_inst(16'h8201, 2, 19'h02180, "moveto_wb");
    run_inst(16'h8202, -1, '0, "movefrom");
    run_inst(16'h8240, -1, '0, "not");
    run_inst(16'h8080, 1, 19'h00000, "nop_decode");
    run_inst(16'hC007, -1, '0, "addi");
    run_inst(16'hD001, -1, '0, "subi");
    run_inst(16'hE001, -1, '0, "andi");
    run_inst(16'hF001, -1, '0, "ori");
    run_inst(16'h3000, -1, '0, "illegal_opc");
    run_inst(16'h8003, -1, '0, "illegal_multi");
    run_inst(16'h8000, -1, '0, "illegal_zero");
    run_inst(16'h8100, -1, '0, "illegal_bit8");
    run_inst(16'h8604, 0, 19'h4D438, "fetch_after_illegal");

    // reset asserted in LD_MEM abandons the load
    inst_bus = 16'h0005;
    exp_q.push_back(fetch_v());
    exp_q.push_back('0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    lit_check("rst_in_ld_mem", 19'h00000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_inst(16'h1003, 0, 19'h4D438, "fetch_after_rst");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
